// File: rtl/counter_host_pkg.sv
// counter_host_pkg: shared FSM states and widths for the counter pad host
package counter_host_pkg;
  localparam int DEF_WIDTH = 41;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    RESET_HOLD, IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_EN, RD_RELEASE, TURN
  } state_t;
endpackage

// File: rtl/counter_host_delta.sv
// counter_host_delta: last-read register and modular difference between consecutive reads
module counter_host_delta
  import counter_host_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cap,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_hist
);
  logic [WIDTH-1:0] r_last, r_delta;
  logic r_has, r_hist;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= '0;
      r_delta <= '0;
      r_has   <= 1'b0;
      r_hist  <= 1'b0;
    end else if (i_cap) begin
      r_last  <= i_data;
      r_delta <= i_data - r_last;
      r_has   <= 1'b1;
      r_hist  <= r_has;
    end else if (i_clr) begin
      r_has <= 1'b0;
    end
  end
  assign o_delta = r_delta;
  assign o_hist  = r_hist;
endmodule

// File: rtl/counter_pad_host.sv
// counter_pad_host: load/read initiator for the counter chip pads; COUNTER_HOST_DELTA_EN adds read-to-read deltas
module counter_pad_host
  import counter_host_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SAMPLE_DLY = 2,
  parameter int TURN_CYC   = 1,
  parameter int RST_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic [WIDTH-1:0] bus_in,
  output logic             web,
  output logic             oeb,
`ifdef COUNTER_HOST_DELTA_EN
  output logic [WIDTH-1:0] rsp_delta,
  output logic             rsp_delta_valid,
`endif
  output logic             chip_rst_n
);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_ready, r_rsp_valid, r_rsp_write, r_bus_oe, r_web, r_oeb, r_chip_rst_n;
  logic [WIDTH-1:0] r_rsp_data, r_bus_out;
  logic w_acc, w_cap;
  assign w_acc = (r_state == IDLE) & req_valid;
  assign w_cap = (r_state == RD_EN) & (r_cnt == CNT_W'(SAMPLE_DLY - 1));
  // chip reset releases one cycle before the first request is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET_HOLD;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_data   <= '0;
      r_bus_out    <= '0;
      r_bus_oe     <= 1'b0;
      r_web        <= 1'b1;
      r_oeb        <= 1'b1;
      r_chip_rst_n <= 1'b0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(RST_HOLD - 1)) r_chip_rst_n <= 1'b1;
          if (r_cnt == CNT_W'(RST_HOLD)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        IDLE: if (w_acc) begin
          r_ready <= 1'b0;
          r_cnt   <= '0;
          if (req_write) begin
            r_state   <= WR_SETUP;
            r_bus_oe  <= 1'b1;
            r_bus_out <= req_data;
          end else begin
            r_state <= RD_EN;
            r_oeb   <= 1'b0;
          end
        end
        WR_SETUP: begin
          r_state <= WR_STROBE;
          r_web   <= 1'b0;
        end
        WR_STROBE: begin
          r_state     <= WR_HOLD;
          r_web       <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_write <= 1'b1;
        end
        WR_HOLD: begin
          r_state     <= TURN;
          r_bus_oe    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_write <= 1'b0;
          r_cnt       <= '0;
        end
        RD_EN: if (w_cap) begin
          r_state     <= RD_RELEASE;
          r_oeb       <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= bus_in;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RD_RELEASE: begin
          r_state     <= TURN;
          r_rsp_valid <= 1'b0;
          r_cnt       <= '0;
        end
        TURN: if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= RESET_HOLD;
      endcase
    end
  end
  assign req_ready  = r_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_write  = r_rsp_write;
  assign rsp_data   = r_rsp_data;
  assign bus_out    = r_bus_out;
  assign bus_oe     = r_bus_oe;
  assign web        = r_web;
  assign oeb        = r_oeb;
  assign chip_rst_n = r_chip_rst_n;
`ifdef COUNTER_HOST_DELTA_EN
  logic w_hist;
  counter_host_delta #(.WIDTH(WIDTH)) u_delta (
    .clk    (clk),
    .rst    (rst),
    .i_cap  (w_cap),
    .i_clr  (w_acc & req_write),
    .i_data (bus_in),
    .o_delta(rsp_delta),
    .o_hist (w_hist)
  );
  assign rsp_delta_valid = w_hist & r_rsp_valid & ~r_rsp_write;
`endif
endmodule

// File: tb/tb_counter_pad_host.sv
// tb_counter_pad_host: transaction-timeline model plus directed literal checks for counter_pad_host
module tb_counter_pad_host;
  localparam int WIDTH = 41, SD = 2, TURN_CYC = 1, RST_HOLD = 4;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_write, rsp_valid, rsp_write, bus_oe, web, oeb, chip_rst_n;
  logic [WIDTH-1:0] req_data, rsp_data, bus_out, bus_in;
`ifdef COUNTER_HOST_DELTA_EN
  logic [WIDTH-1:0] rsp_delta, g_d, m_delta;
  logic rsp_delta_valid, g_dv, m_have, m_dv;
`endif
  int checks = 0, errors = 0;

  counter_pad_host #(.WIDTH(WIDTH), .SAMPLE_DLY(SD), .TURN_CYC(TURN_CYC), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .web(web), .oeb(oeb),
`ifdef COUNTER_HOST_DELTA_EN
    .rsp_delta(rsp_delta), .rsp_delta_valid(rsp_delta_valid),
`endif
    .chip_rst_n(chip_rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  // Model: each interval's outputs follow from the cycle offset since the last accept or reset
  int cyc = 0, rel = 0, t_acc = 0, ready_at = 0, k;
  bit m_on = 0, act = 0, m_wr = 0, p_ready = 0;
  logic [WIDTH-1:0] m_d, m_rsp;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      m_on = 1; rel = cyc; ready_at = cyc + RST_HOLD + 1; act = 0; m_rsp = '0;
`ifdef COUNTER_HOST_DELTA_EN
      m_have = 0; m_dv = 0;
`endif
    end else if (m_on) begin
      if (p_ready && req_valid) begin
        t_acc = cyc - 1; act = 1; m_wr = req_write; m_d = req_data;
        ready_at = t_acc + (req_write ? 4 + TURN_CYC : SD + 2 + TURN_CYC);
`ifdef COUNTER_HOST_DELTA_EN
        if (req_write) m_have = 0;
`endif
      end
      if (act && !m_wr && cyc - t_acc == SD + 1) begin
`ifdef COUNTER_HOST_DELTA_EN
        m_delta = bus_in - m_rsp; m_dv = m_have; m_have = 1;
`endif
        m_rsp = bus_in;
      end
    end
    if (m_on) begin
      if (act && cyc >= ready_at) act = 0;
      k = cyc - t_acc;
      chk("m_bus_oe", bus_oe, act && m_wr && k <= 3);
      if (act && m_wr && k <= 3) chk("m_bus_out", bus_out, m_d);
      chk("m_web", web, !(act && m_wr && k == 2));
      chk("m_oeb", oeb, !(act && !m_wr && k <= SD));
      chk("m_rsp_valid", rsp_valid, act && k == (m_wr ? 3 : SD + 1));
      chk("m_rsp_write", rsp_write, act && m_wr && k == 3);
      chk("m_rsp_data", rsp_data, m_rsp);
      chk("m_req_ready", req_ready, cyc >= ready_at);
      chk("m_chip_rst_n", chip_rst_n, cyc - rel >= RST_HOLD);
      chk("inv_oe_oeb", bus_oe && !oeb, 0);
      chk("inv_web_oe", !web && !bus_oe, 0);
      chk("inv_web_oeb", !web && !oeb, 0);
`ifdef COUNTER_HOST_DELTA_EN
      chk("m_delta_valid", rsp_delta_valid, act && !m_wr && k == SD + 1 && m_dv);
      if (act && !m_wr && k == SD + 1 && m_dv) chk("m_delta", rsp_delta, m_delta);
`endif
      p_ready = cyc >= ready_at;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  // Directed transaction with literal timing expectations at default parameters
  task automatic txn(input bit wr, input logic [WIDTH-1:0] v);
    wait_ready();
    req_valid = 1; req_write = wr; req_data = v;
    if (!wr) bus_in = v;
    for (int k2 = 1; k2 <= 6; k2++) begin
      @(negedge clk);
      req_valid = 0;
      if (wr) begin
        chk("w_bus_oe", bus_oe, k2 <= 3);
        chk("w_web", web, k2 != 2);
        if (k2 <= 3) chk("w_bus_out", bus_out, v);
        chk("w_rsp_valid", rsp_valid, k2 == 3);
        if (k2 == 3) chk("w_rsp_write", rsp_write, 1);
        chk("w_ready", req_ready, k2 >= 5);
      end else begin
        chk("r_oeb", oeb, k2 > 2);
        chk("r_bus_oe", bus_oe, 0);
        chk("r_rsp_valid", rsp_valid, k2 == 3);
        if (k2 == 3) chk("r_rsp_data", rsp_data, v);
        chk("r_ready", req_ready, k2 >= 5);
`ifdef COUNTER_HOST_DELTA_EN
        if (k2 == 3) chk("r_delta_valid", rsp_delta_valid, g_dv);
        if (k2 == 3 && g_dv) chk("r_delta", rsp_delta, g_d);
`endif
      end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_write = 0; req_data = '0; bus_in = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_chip_rst_n", chip_rst_n, i >= 4);
      chk("rst_ready", req_ready, i >= 5);
      if (i == 0) begin
        chk("rst_web", web, 1); chk("rst_oeb", oeb, 1); chk("rst_bus_oe", bus_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_data", rsp_data, 0); chk("rst_bus_out", bus_out, 0);
      end
      if (i < 5) @(negedge clk);
    end
`ifdef COUNTER_HOST_DELTA_EN
    g_dv = 0; txn(0, 41'h1FF_FFFF_FFFE);
    g_dv = 1; g_d = 41'd5; txn(0, 41'h3);
    g_dv = 0;
`endif
    txn(1, 41'h1_2345_6789A);
    txn(0, 41'h0_0000_00FF);
    wait_ready();
    req_valid = 1; req_write = 1; req_data = 41'h0_AAAA_5555;
    @(negedge clk);
    req_write = 0;
    for (int k2 = 2; k2 <= 5; k2++) begin
      @(negedge clk);
      chk("wr_rd_ready", req_ready, k2 == 5);
    end
    @(negedge clk);
    req_valid = 0;
    chk("wr_rd_oeb", oeb, 0);
    wait_ready();
    req_valid = 1; req_write = 0;
    @(negedge clk);
    req_valid = 0;
    chk("rdrst_oeb_low", oeb, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rdrst_oeb", oeb, 1);
    for (int i = 0; i < 6; i++) begin
      chk("rdrst_chip_rst_n", chip_rst_n, i >= 4);
      chk("rdrst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus_in = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 7)) : rnd();
      rst = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 1);
      req_write = $urandom_range(0, 1);
      req_data = rnd();
    end
    @(negedge clk);
    rst = 0; req_valid = 0;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/counter_pad_host.md
# counter_pad_host

Host-side initiator for the counter chip's 45-pin pad interface: issues load and read transactions to the chip's 41-bit counter over the shared bidirectional count bus, generating `web`, `oeb`, chip reset and bus turnaround. Sits in the FPGA/test-fixture wrapper between a simple valid/ready request port and the tristate pad buffers driving the chip.

## Interface
- `WIDTH`, 41: counter/bus width.
- `SAMPLE_DLY`, 2: cycles `oeb` is low before `bus_in` is sampled (≥1).
- `TURN_CYC`, 1: idle cycles with nobody driving the bus after each transaction (≥1).
- `RST_HOLD`, 4: cycles `chip_rst_n` stays low after `rst` deasserts (≥1).

Ports:
- `clk`  in  1  single clock, shared with the chip.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = load counter, 0 = read counter.
- `req_data`  in  WIDTH  load value.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_write`  out  1  completed transaction was a write.
- `rsp_data`  out  WIDTH  read value (holds last read otherwise).
- `bus_out`  out  WIDTH  value driven onto count pads.
- `bus_oe`  out  1  host drives count pads.
- `bus_in`  in  WIDTH  count pad input.
- `web`  out  1  chip write strobe, active low.
- `oeb`  out  1  chip output enable, active low.
- `chip_rst_n`  out  1  chip reset, active low.

## Operation
- States: RESET_HOLD, IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_EN, RD_RELEASE, TURN.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_write`=0, `rsp_data`=0, `bus_out`=0, `bus_oe`=0, `web`=1, `oeb`=1, `chip_rst_n`=0; state RESET_HOLD.
- RESET_HOLD: counts `RST_HOLD` cycles, then `chip_rst_n`=1, → IDLE.
- IDLE: `req_ready`=1; on accept, latch `req_data`/`req_write`; write → WR_SETUP, read → RD_EN.
- Write: WR_SETUP `bus_oe`=1, `bus_out`=data; WR_STROBE `web`=0 (chip loads on this cycle's closing edge); WR_HOLD `web`=1, bus still driven, `rsp_valid`=1, `rsp_write`=1; → TURN.
- Read: RD_EN `oeb`=0 for `SAMPLE_DLY` cycles, `bus_in` captured on the last; RD_RELEASE `oeb`=1, `rsp_valid`=1, `rsp_data`=captured; → TURN.
- TURN: `bus_oe`=0, `web`=`oeb`=1 for `TURN_CYC` cycles, → IDLE.
- Invariants: never `bus_oe`=1 while `oeb`=0; `web`=0 only while `bus_oe`=1; `web` and `oeb` never both low.
- `bus_in` unsynchronised (chip shares `clk`).
- `rst` at any cycle: reset values at the next edge, bus released, in-flight response dropped, `chip_rst_n` re-asserted for full hold.

## Timing
- Accept at cycle T. Write: `bus_oe` rises T+1, `web` low T+2 only, `rsp_valid` T+3, `bus_oe` falls T+4.
- Read: `oeb` low T+1..T+SAMPLE_DLY, `rsp_valid` T+SAMPLE_DLY+1.
- `req_ready` returns at T+4+TURN_CYC for writes, T+SAMPLE_DLY+2+TURN_CYC for reads (T+5 for both at defaults).
- `req_ready` is 0 in every non-IDLE state; back-to-back requests are never accepted.

## Configuration
- `COUNTER_HOST_DELTA_EN`: adds outputs `rsp_delta` (WIDTH) and `rsp_delta_valid` (1). On each read, `rsp_delta` = current read − previous read, modulo 2^WIDTH (wrap-around yields a small positive value). `rsp_delta_valid`=1 only with `rsp_valid` for a read that has a prior read since reset or since the last write; a write invalidates the history. Without the macro the ports and history register are absent.

## Structure
- Package `counter_host_pkg`: state enum, default `WIDTH`, counter width for the delay/turn/hold counters.
- Sub-module `counter_host_delta` (last-read register + subtractor), instantiated only under `COUNTER_HOST_DELTA_EN`.

## Test plan
- Reset: `rst` 3 cycles → `chip_rst_n`=0 until 4 cycles after release, `req_ready` first high 5 cycles after release, all outputs at reset values.
- Write 41'h1_2345_6789A at T → `web` low only at T+2, `bus_out`=value with `bus_oe`=1 T+1..T+3, `rsp_valid`/`rsp_write` at T+3, `req_ready` at T+5.
- Read with chip model driving 41'h0_0000_00FF → `oeb` low T+1..T+2, `rsp_data`=41'hFF at T+3, `bus_oe`=0 throughout.
- Write then immediate read request held valid → read accepted at T+5, assertion checker confirms no bus contention or `web`/`oeb` overlap.
- `rst` asserted during RD_EN → next cycle `oeb`=1, no `rsp_valid`, `chip_rst_n` low 4 cycles.
- With `COUNTER_HOST_DELTA_EN`: reads of 41'h1FF_FFFF_FFFE then 41'h3 → second `rsp_delta`=5 with `rsp_delta_valid`=1; first read `rsp_delta_valid`=0.
